// File: rtl/add_sequencer_pkg.sv
// Shared types for the word-serial adder sequencer.
package add_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/add_slice.sv
// One-word combinational adder with carry in; the single arithmetic resource
// that the sequencer reuses for every word of the wide sum.
module add_slice #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};

endmodule

// File: rtl/add_sequencer.sv
// Wide adder built by stepping one narrow slice over NWORDS words, LSW first,
// with valid/ready handshakes on the operand and result sides.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand pair
// RUN   | one word per cycle through the slice, carry kept in carry_q
// DONE  | result held with out_valid high until out_ready
module add_sequencer
  import add_sequencer_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NWORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH*NWORDS-1:0]  a,
  input  logic [WIDTH*NWORDS-1:0]  b,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH*NWORDS-1:0]  s,
  output logic                     cout,
  output logic                     busy
);

  localparam int IDXW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  state_t                         state_q;
  logic [IDXW-1:0]                idx_q;
  logic [NWORDS-1:0][WIDTH-1:0]   a_q;
  logic [NWORDS-1:0][WIDTH-1:0]   b_q;
  logic [NWORDS-1:0][WIDTH-1:0]   s_q;
  logic                           carry_q;
  logic                           cout_q;

  logic [WIDTH-1:0]               sum_d;
  logic                           carry_d;

  add_slice #(.WIDTH(WIDTH)) u_slice (
    .a  (a_q[idx_q]),
    .b  (b_q[idx_q]),
    .ci (carry_q),
    .s  (sum_d),
    .co (carry_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          s_q[idx_q] <= sum_d;
          carry_q    <= carry_d;
          if (idx_q == LAST_IDX) begin
            cout_q  <= carry_d;
            idx_q   <= '0;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode the state register only, so no input reaches an output.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign s         = s_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_add_sequencer.sv
// Directed and randomized checks of add_sequencer against an arithmetic
// reference ({cout,s} = a+b+cin) with a queue of outstanding operations.
module tb_add_sequencer;

  localparam int NW = 4;
  localparam int W  = 8 * NW;

  logic         clk;
  logic         rst;
  logic         in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [W-1:0] a, b, s;

  logic         in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, busy1;
  logic [7:0]   a1, b1, s1;

  int n_cmp = 0;
  int n_bad = 0;

  add_sequencer #(.WIDTH(8), .NWORDS(NW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .cout(cout), .busy(busy)
  );

  add_sequencer #(.WIDTH(8), .NWORDS(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .s(s1), .cout(cout1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] e);
    n_cmp++;
    assert (obs === e) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
    end
  endtask

  // Single operation with out_ready held high; checks exact latency and 1-cycle out_valid.
  task automatic op_fixed(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc);
    logic [W:0] e;
    e = {1'b0, ta} + {1'b0, tb} + (W+1)'(tc);
    a = ta; b = tb; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    chk({tag, "_no_ready"}, 64'(in_ready), 64'd0);
    for (int k = 1; k < NW; k++) begin
      tick();
      chk({tag, "_early_valid"}, 64'(out_valid), 64'd0);
    end
    tick();
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_s"}, 64'(s), 64'(e[W-1:0]));
    chk({tag, "_cout"}, 64'(cout), 64'(e[W]));
    tick();
    chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [W:0] ex, ey;
    logic [W:0] q[$];
    int sent, got, cyc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_s", 64'(s), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);

    op_fixed("carry", 32'h0000_00FF, 32'h0000_0001, 1'b0);
    op_fixed("ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);

    // Backpressure: result held in DONE while a new operand waits.
    a = $urandom; b = $urandom; cin = 1'($urandom);
    ex = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    a = $urandom; b = $urandom; cin = 1'($urandom);
    ey = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
    for (int k = 0; k < NW; k++) tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_s", 64'(s), 64'(ex[W-1:0]));
      chk("bp_cout", 64'(cout), 64'(ex[W]));
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_accept", 64'(busy), 64'd1);
    for (int k = 0; k < NW; k++) tick();
    chk("bp2_valid", 64'(out_valid), 64'd1);
    chk("bp2_s", 64'(s), 64'(ey[W-1:0]));
    chk("bp2_cout", 64'(cout), 64'(ey[W]));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset while RUN is at word index 2.
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_in_ready", 64'(in_ready), 64'd1);
    chk("mrst_out_valid", 64'(out_valid), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_s", 64'(s), 64'd0);
    chk("mrst_cout", 64'(cout), 64'd0);
    op_fixed("after_rst", 32'h1234_5678, 32'h1111_1111, 1'b0);

    // Single-word configuration.
    a1 = 8'h80; b1 = 8'h80; cin1 = 1'b0; in_valid1 = 1'b1; out_ready1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    chk("nw1_busy", 64'(busy1), 64'd1);
    chk("nw1_early", 64'(out_valid1), 64'd0);
    tick();
    chk("nw1_valid", 64'(out_valid1), 64'd1);
    chk("nw1_s", 64'(s1), 64'h00);
    chk("nw1_cout", 64'(cout1), 64'd1);
    tick();
    chk("nw1_drop", 64'(out_valid1), 64'd0);

    // Random regression against the arithmetic model.
    sent = 0; got = 0; cyc = 0;
    while (got < 512 && cyc < 20000) begin
      if (sent < 512) begin
        in_valid = 1'($urandom);
        a = $urandom; b = $urandom; cin = 1'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = 1'($urandom);
      if (in_valid && in_ready) begin
        q.push_back({1'b0, a} + {1'b0, b} + (W+1)'(cin));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("rnd_dup", 64'(q.size()), 64'd1);
        end else begin
          ex = q.pop_front();
          chk("rnd_sum", 64'({cout, s}), 64'(ex));
        end
        got++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rnd_count", 64'(got), 64'd512);
    chk("rnd_lost", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
